// File: rtl/fetch_buffer_pkg.sv
// Shared constants and entry type for the instruction fetch buffer.
`ifndef XLEN
`define XLEN 32
`endif

package fetch_buffer_pkg;
  localparam int FB_DEPTH    = 8;
  localparam int FETCH_WIDTH = 3;
  localparam int XLEN        = `XLEN;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fb_entry_t;
endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle between icache, fetch buffer and dispatch; lane 2 is always the oldest.
interface fetch_buffer_if
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
);
  // Handshake: in_valid offers a run of instructions and `accepted` (same cycle,
  // combinational) says how many of the oldest were taken; out_valid shows the
  // oldest entries and `deq_count` says how many dispatch consumed this cycle.
  logic                                take_branch;
  logic [FETCH_WIDTH-1:0]              in_valid;
  logic [FETCH_WIDTH-1:0][31:0]        in_inst;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]    in_pc;
  logic [1:0]                          accepted;
  logic [FETCH_WIDTH-1:0]              out_valid;
  logic [FETCH_WIDTH-1:0][31:0]        out_inst;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]    out_pc;
  logic [1:0]                          deq_count;
  logic [$clog2(DEPTH):0]              free_slots;
  logic                                empty;
  logic                                full;

  modport master (
    output take_branch, in_valid, in_inst, in_pc, deq_count,
    input  accepted, out_valid, out_inst, out_pc, free_slots, empty, full
  );

  modport slave (
    input  take_branch, in_valid, in_inst, in_pc, deq_count,
    output accepted, out_valid, out_inst, out_pc, free_slots, empty, full
  );
endinterface

// File: rtl/fetch_buffer_ptr_add.sv
// Modular pointer adder: ptr + inc wrapped to a power-of-two depth.
module fb_ptr_add #(
  parameter int DEPTH = 8
) (
  input  logic [$clog2(DEPTH)-1:0] ptr,
  input  logic [1:0]               inc,
  output logic [$clog2(DEPTH)-1:0] sum
);
  localparam int PW = $clog2(DEPTH);

  // Depth is a power of two, so truncation is the modulo.
  assign sum = ptr + PW'(inc);
endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction queue between icache and dispatch; three in, three out per cycle.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int FB_DEPTH = fetch_buffer_pkg::FB_DEPTH
) (
  input  logic           clock,
  input  logic           reset,
  fetch_buffer_if.slave  fb
);
  localparam int PW = $clog2(FB_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fb_entry_t     mem_q [FB_DEPTH];
  fb_entry_t     mem_d [FB_DEPTH];

  logic [1:0]    run, acc, eff_deq;
  logic [CW-1:0] space;
  logic [PW-1:0] head_adv, tail_adv;
  logic [PW-1:0] wr_idx [FETCH_WIDTH];
  logic [PW-1:0] rd_idx [FETCH_WIDTH];

  // Only the leading contiguous run from the oldest lane is accepted.
  always_comb begin
    run = 2'd0;
    if (fb.in_valid[2]) begin
      if (fb.in_valid[1]) run = fb.in_valid[0] ? 2'd3 : 2'd2;
      else                run = 2'd1;
    end
  end

  // Space comes from the start-of-cycle count; dequeued slots are not reused.
  always_comb begin
    space = CW'(FB_DEPTH) - count_q;
    acc   = 2'd0;
    if (!fb.take_branch) begin
      if (CW'(run) > space) acc = space[1:0];
      else                  acc = run;
    end
    eff_deq = fb.deq_count;
    if (CW'(fb.deq_count) > count_q) eff_deq = count_q[1:0];
  end

  fb_ptr_add #(.DEPTH(FB_DEPTH)) u_head_add (.ptr(head_q), .inc(eff_deq), .sum(head_adv));
  fb_ptr_add #(.DEPTH(FB_DEPTH)) u_tail_add (.ptr(tail_q), .inc(acc),     .sum(tail_adv));

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    fb_ptr_add #(.DEPTH(FB_DEPTH)) u_wr_add (.ptr(tail_q), .inc(2'(i)), .sum(wr_idx[i]));
    fb_ptr_add #(.DEPTH(FB_DEPTH)) u_rd_add (.ptr(head_q), .inc(2'(i)), .sum(rd_idx[i]));
  end

  always_comb begin
    head_d  = head_adv;
    tail_d  = tail_adv;
    count_d = count_q + CW'(acc) - CW'(eff_deq);
    if (fb.take_branch) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (2'(i) < acc) begin
        mem_d[wr_idx[i]].inst = fb.in_inst[2-i];
        mem_d[wr_idx[i]].pc   = fb.in_pc[2-i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    fb.out_valid = '0;
    fb.out_inst  = '0;
    fb.out_pc    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      fb.out_valid[2-i] = (count_q > CW'(i));
      fb.out_inst[2-i]  = mem_q[rd_idx[i]].inst;
      fb.out_pc[2-i]    = mem_q[rd_idx[i]].pc;
    end
  end

  assign fb.accepted   = acc;
  assign fb.free_slots = CW'(FB_DEPTH) - count_q;
  assign fb.empty      = (count_q == '0);
  assign fb.full       = (count_q == CW'(FB_DEPTH));
endmodule
